// File: rtl/conv_deinterleaver.sv
// -----------------------------------------------------------------------------
// conv_deinterleaver
//
// Receive-side convolutional deinterleaver, the inverse of the transmit
// interleaver whose branch j delays by j*DEPTH_UNIT visits. A byte
// commutator spreads accepted bytes over BRANCHES branches. Branch j is a
// shift chain of (BRANCHES-1-j)*DEPTH_UNIT cells, so every byte sees the
// same total interleaver+deinterleaver delay of
// BRANCHES*(BRANCHES-1)*DEPTH_UNIT bytes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = reset)
//   in_valid     in_data/in_sync valid; one byte consumed per valid cycle
//   in_data      received interleaved byte
//   in_sync      packet-sync marker, forces the byte into branch 0
//   out_valid    in_valid delayed by one clock
//   out_data     deinterleaved byte (held while out_valid=0)
//   out_sync     sync marker travelling with out_data
//   out_primed   high once every branch holds real data
//   branch_idx   branch that received the most recently accepted byte
//   sync_err     (CONV_DEINT_SYNC_CHECK_EN) sync seen with commutator off 0
//   sync_err_cnt (CONV_DEINT_SYNC_CHECK_EN) saturating count of sync_err
//
// Optional feature macro: CONV_DEINT_SYNC_CHECK_EN adds the sync_err and
// sync_err_cnt outputs. Without it, realignment on in_sync still happens.
// -----------------------------------------------------------------------------
module conv_deinterleaver #(
  parameter int BRANCHES   = 12,
  parameter int DEPTH_UNIT = 17,
  parameter int DATA_W     = 8,
  localparam int IDX_W     = (BRANCHES > 1) ? $clog2(BRANCHES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sync,
  output logic              out_primed,
  output logic [IDX_W-1:0]  branch_idx
`ifdef CONV_DEINT_SYNC_CHECK_EN
  ,
  output logic              sync_err,
  output logic [7:0]        sync_err_cnt
`endif
);

  localparam int CELL_W = DATA_W + 1;
  localparam int FILL   = BRANCHES * (BRANCHES - 1) * DEPTH_UNIT;
  localparam int FILL_W = $clog2(FILL + 1);

  localparam logic [IDX_W-1:0]  LAST_BR  = IDX_W'(BRANCHES - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL);

  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  sel;
  logic              accept;
  logic [CELL_W-1:0] in_cell;
  logic [BRANCHES-1:0] wr_en;
  logic [CELL_W-1:0] br_out [BRANCHES];
  logic [CELL_W-1:0] sel_out;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sync_q, out_sync_d;
  logic              primed_q, primed_d;
  logic [IDX_W-1:0]  branch_idx_q, branch_idx_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // ---------------------------------------------------------------------------
  // Commutator: a sync byte always lands in branch 0, which realigns the
  // stream in the same cycle without dropping or duplicating the byte.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept  = in_valid;
    in_cell = {in_sync, in_data};
    sel     = (in_valid && in_sync) ? '0 : cur_q;
    cur_d   = cur_q;
    if (accept) begin
      cur_d = (sel == LAST_BR) ? '0 : sel + IDX_W'(1);
    end
    wr_en = '0;
    for (int j = 0; j < BRANCHES; j++) begin
      wr_en[j] = accept && (sel == IDX_W'(j));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch delay lines. A chain shifts only when its branch is written; the
  // cell pushed out of the far end is that branch's output. The last branch
  // has no cells and passes the incoming byte straight through.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < BRANCHES; j++) begin : g_branch
    localparam int L = (BRANCHES - 1 - j) * DEPTH_UNIT;
    if (L > 0) begin : g_chain
      logic [CELL_W-1:0] cell_q [L];
      logic [CELL_W-1:0] cell_d [L];

      always_comb begin
        cell_d = cell_q;
        if (wr_en[j]) begin
          cell_d[0] = in_cell;
          for (int k = 1; k < L; k++) begin
            cell_d[k] = cell_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < L; k++) begin
            cell_q[k] <= '0;
          end
        end else begin
          cell_q <= cell_d;
        end
      end

      assign br_out[j] = cell_q[L-1];
    end else begin : g_pass
      assign br_out[j] = in_cell;
    end
  end

  always_comb begin
    sel_out = '0;
    for (int j = 0; j < BRANCHES; j++) begin
      if (sel == IDX_W'(j)) begin
        sel_out = br_out[j];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage and fill tracking. Priming completes with the
  // byte after FILL accepted bytes, the first one whose branch-0 data is real.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = in_valid;
    out_data_d   = out_data_q;
    out_sync_d   = out_sync_q;
    branch_idx_d = branch_idx_q;
    fill_d       = fill_q;
    primed_d     = primed_q;
    if (accept) begin
      out_data_d   = sel_out[DATA_W-1:0];
      out_sync_d   = sel_out[DATA_W];
      branch_idx_d = sel;
      if (fill_q == FILL_MAX) begin
        primed_d = 1'b1;
      end else begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sync_q   <= 1'b0;
      branch_idx_q <= '0;
      fill_q       <= '0;
      primed_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sync_q   <= out_sync_d;
      branch_idx_q <= branch_idx_d;
      fill_q       <= fill_d;
      primed_q     <= primed_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sync   = out_sync_q;
  assign out_primed = primed_q;
  assign branch_idx = branch_idx_q;

`ifdef CONV_DEINT_SYNC_CHECK_EN
  logic       sync_err_q, sync_err_d;
  logic [7:0] sync_err_cnt_q, sync_err_cnt_d;

  // A sync byte arriving while the commutator is off branch 0 means the
  // stream had slipped; the flag lines up with that byte's output.
  always_comb begin
    sync_err_d     = accept && in_sync && (cur_q != '0);
    sync_err_cnt_d = sync_err_cnt_q;
    if (sync_err_d && (sync_err_cnt_q != 8'hFF)) begin
      sync_err_cnt_d = sync_err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_err_q     <= 1'b0;
      sync_err_cnt_q <= '0;
    end else begin
      sync_err_q     <= sync_err_d;
      sync_err_cnt_q <= sync_err_cnt_d;
    end
  end

  assign sync_err     = sync_err_q;
  assign sync_err_cnt = sync_err_cnt_q;
`endif

endmodule

// File: tb/tb_conv_deinterleaver.sv
module tb_conv_deinterleaver;

  localparam int DW    = 8;
  localparam int SB    = 3;
  localparam int SD    = 2;
  localparam int DB    = 12;
  localparam int DD    = 17;
  localparam int DFILL = DB * (DB - 1) * DD;
  localparam int PKT   = 204;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Small configuration instance
  logic          s_reset, s_in_valid, s_in_sync;
  logic [DW-1:0] s_in_data;
  logic          s_out_valid, s_out_sync, s_out_primed;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_branch_idx;

  // Default configuration instance
  logic          d_reset, d_in_valid, d_in_sync;
  logic [DW-1:0] d_in_data;
  logic          d_out_valid, d_out_sync, d_out_primed;
  logic [DW-1:0] d_out_data;
  logic [3:0]    d_branch_idx;

`ifdef CONV_DEINT_SYNC_CHECK_EN
  logic       s_sync_err, d_sync_err;
  logic [7:0] s_sync_err_cnt, d_sync_err_cnt;
`endif

  conv_deinterleaver #(.BRANCHES(SB), .DEPTH_UNIT(SD), .DATA_W(DW)) u_small (
    .clk        (clk),
    .reset      (s_reset),
    .in_valid   (s_in_valid),
    .in_data    (s_in_data),
    .in_sync    (s_in_sync),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .out_sync   (s_out_sync),
    .out_primed (s_out_primed),
    .branch_idx (s_branch_idx)
`ifdef CONV_DEINT_SYNC_CHECK_EN
    ,
    .sync_err     (s_sync_err),
    .sync_err_cnt (s_sync_err_cnt)
`endif
  );

  conv_deinterleaver #(.BRANCHES(DB), .DEPTH_UNIT(DD), .DATA_W(DW)) u_dut (
    .clk        (clk),
    .reset      (d_reset),
    .in_valid   (d_in_valid),
    .in_data    (d_in_data),
    .in_sync    (d_in_sync),
    .out_valid  (d_out_valid),
    .out_data   (d_out_data),
    .out_sync   (d_out_sync),
    .out_primed (d_out_primed),
    .branch_idx (d_branch_idx)
`ifdef CONV_DEINT_SYNC_CHECK_EN
    ,
    .sync_err     (d_sync_err),
    .sync_err_cnt (d_sync_err_cnt)
`endif
  );

  // Reference model: source stream history plus a transmit interleaver
  // built from per-branch visit histories (branch b delays b*DD visits).
  // Interleaver followed by deinterleaver reproduces the source delayed by
  // DFILL bytes, with zeros before that.
  logic [8:0] src [4096];
  logic [8:0] il_hist [DB][256];
  int         il_cnt [DB];
  int         src_n;
  logic [8:0] d_last;
  logic       d_last_primed;
  logic [3:0] d_last_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    src_n = 0;
    for (int b = 0; b < DB; b++) il_cnt[b] = 0;
    d_last        = '0;
    d_last_primed = 1'b0;
    d_last_idx    = '0;
  endtask

  task automatic s_step(input logic v, input logic [7:0] dat, input logic syn);
    s_in_valid = v;
    s_in_data  = dat;
    s_in_sync  = syn;
    @(posedge clk);
    #1;
  endtask

  task automatic d_step(input logic v, input logic [7:0] dat, input logic syn);
    d_in_valid = v;
    d_in_data  = dat;
    d_in_sync  = syn;
    @(posedge clk);
    #1;
  endtask

  // Stream nbytes packet bytes through the interleaver model into the DUT,
  // with random idle cycles, checking every output cycle.
  task automatic d_run(input int nbytes);
    int k, b, v;
    logic [8:0] byt, ilo, exp9;
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        d_step(1'b0, 8'($urandom), 1'($urandom));
        chk("d_idle", 64'({d_out_valid, d_out_sync, d_out_primed, d_branch_idx, d_out_data}),
            64'({1'b0, d_last[8], d_last_primed, d_last_idx, d_last[7:0]}));
      end
      src_n++;
      k = src_n;
      if ((k - 1) % PKT == 0) byt = {1'b1, 8'h47};
      else                    byt = {1'b0, 8'($urandom)};
      src[k] = byt;
      b = (k - 1) % DB;
      v = il_cnt[b];
      il_hist[b][v] = byt;
      il_cnt[b]++;
      ilo = (v >= b * DD) ? il_hist[b][v - b * DD] : 9'h0;
      d_step(1'b1, ilo[7:0], ilo[8]);
      exp9          = (k > DFILL) ? src[k - DFILL] : 9'h0;
      d_last        = exp9;
      d_last_primed = (k > DFILL);
      d_last_idx    = 4'(b);
      chk("d_data", 64'({d_out_sync, d_out_data}), 64'(exp9));
      chk("d_ctrl", 64'({d_out_valid, d_out_primed, d_branch_idx}),
          64'({1'b1, d_last_primed, d_last_idx}));
    end
    d_in_valid = 1'b0;
    d_in_sync  = 1'b0;
  endtask

  task automatic d_async_reset(input string tag);
    #2;
    d_reset = 1'b0;
    #1;
    chk(tag, 64'({d_out_valid, d_out_sync, d_out_primed, d_branch_idx, d_out_data}), 64'(0));
    d_in_valid = 1'b1;
    d_in_sync  = 1'b1;
    d_in_data  = 8'hA5;
    @(posedge clk);
    #1;
    chk({tag, "_held"}, 64'({d_out_valid, d_out_sync, d_out_primed, d_branch_idx, d_out_data}),
        64'(0));
    d_in_valid = 1'b0;
    d_in_sync  = 1'b0;
    d_reset    = 1'b1;
    model_reset();
  endtask

  initial begin
    int br, dly, ed, n, t;
    logic [7:0] ldat;
    logic       lsync, lprim;
    logic [1:0] lidx;

    s_reset = 1'b0; s_in_valid = 1'b0; s_in_sync = 1'b0; s_in_data = '0;
    d_reset = 1'b0; d_in_valid = 1'b0; d_in_sync = 1'b0; d_in_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("s_reset_state", 64'({s_out_valid, s_out_sync, s_out_primed, s_branch_idx, s_out_data}), 64'(0));
    chk("d_reset_state", 64'({d_out_valid, d_out_sync, d_out_primed, d_branch_idx, d_out_data}), 64'(0));
    s_reset = 1'b1;
    d_reset = 1'b1;

    // Small config, continuous stream 1,2,3,... with sync on 1,4,7,...
    for (int i = 1; i <= 24; i++) begin
      s_step(1'b1, 8'(i), (i % 3) == 1);
      br  = (i - 1) % SB;
      dly = (SB - 1 - br) * SD * SB;
      ed  = (i > dly) ? i - dly : 0;
      chk("s_cont_data", 64'(s_out_data), 64'(ed));
      chk("s_cont_flags", 64'({s_out_valid, s_out_sync, s_out_primed, s_branch_idx}),
          64'({1'b1, (i > dly) && (((i - dly) % 3) == 1), i > 12, 2'(br)}));
    end
    s_in_valid = 1'b0;

    // Asynchronous reset of the small instance while it holds real data
    s_reset = 1'b0;
    #1;
    chk("s_async_reset", 64'({s_out_valid, s_out_sync, s_out_primed, s_branch_idx, s_out_data}), 64'(0));
    @(posedge clk);
    #1;
    s_reset = 1'b1;

    // Small config, in_valid pattern 1,0,0,1: same byte sequence, gaps hold
    n = 0; t = 0;
    ldat = '0; lsync = 1'b0; lprim = 1'b0; lidx = '0;
    while (n < 24) begin
      if ((t % 4 == 0) || (t % 4 == 3)) begin
        n++;
        s_step(1'b1, 8'(n), (n % 3) == 1);
        br    = (n - 1) % SB;
        dly   = (SB - 1 - br) * SD * SB;
        ldat  = (n > dly) ? 8'(n - dly) : 8'h0;
        lsync = (n > dly) && (((n - dly) % 3) == 1);
        lprim = (n > 12);
        lidx  = 2'(br);
        chk("s_tog_byte", 64'({s_out_valid, s_out_sync, s_out_primed, s_branch_idx, s_out_data}),
            64'({1'b1, lsync, lprim, lidx, ldat}));
      end else begin
        s_step(1'b0, 8'($urandom), 1'($urandom));
        chk("s_tog_gap", 64'({s_out_valid, s_out_sync, s_out_primed, s_branch_idx, s_out_data}),
            64'({1'b0, lsync, lprim, lidx, ldat}));
      end
      t++;
    end
    s_in_valid = 1'b0;
    s_in_sync  = 1'b0;
`ifdef CONV_DEINT_SYNC_CHECK_EN
    chk("s_no_sync_err", 64'(s_sync_err_cnt), 64'(0));
`endif

    // Defaults: interleaver looped into deinterleaver, 14 packets
    d_run(14 * PKT);
`ifdef CONV_DEINT_SYNC_CHECK_EN
    chk("d_loop_no_sync_err", 64'(d_sync_err_cnt), 64'(0));
`endif
    d_async_reset("d_async_rst_a");

    // Restart, reset again at byte 500, then re-prime from scratch
    d_run(500);
    d_async_reset("d_async_rst_b");
    d_run(DFILL + 60);
    d_async_reset("d_async_rst_c");

    // Resync: sync byte arrives with the commutator at branch 5
    for (int i = 1; i <= 5; i++) begin
      d_step(1'b1, 8'(8'h80 + i), 1'b0);
      chk("d_rs_pre_idx", 64'(d_branch_idx), 64'(i - 1));
    end
    d_step(1'b1, 8'h86, 1'b1);
    chk("d_rs_sync_idx", 64'(d_branch_idx), 64'(0));
`ifdef CONV_DEINT_SYNC_CHECK_EN
    chk("d_rs_err_pulse", 64'({d_sync_err, d_sync_err_cnt}), 64'({1'b1, 8'd1}));
`endif
    for (int i = 7; i <= 17; i++) begin
      d_step(1'b1, 8'(8'h80 + i), 1'b0);
      chk("d_rs_post_idx", 64'(d_branch_idx), 64'(i - 6));
`ifdef CONV_DEINT_SYNC_CHECK_EN
      chk("d_rs_err_clear", 64'({d_sync_err, d_sync_err_cnt}), 64'({1'b0, 8'd1}));
`endif
    end
    // byte 17 sits on the zero-delay branch and passes straight through
    chk("d_rs_passthru", 64'({d_out_valid, d_out_sync, d_out_data}), 64'({1'b1, 1'b0, 8'h91}));
    d_step(1'b1, 8'h47, 1'b1);
    chk("d_rs_aligned_idx", 64'(d_branch_idx), 64'(0));
`ifdef CONV_DEINT_SYNC_CHECK_EN
    chk("d_rs_aligned_err", 64'({d_sync_err, d_sync_err_cnt}), 64'({1'b0, 8'd1}));
`endif
    d_step(1'b0, 8'h00, 1'b0);
    chk("d_rs_tail_valid", 64'(d_out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
